// File: rtl/phase_2b_pkg.sv
// Shared definitions for the phase_2b rotator: default widths and the reference rotation.
// Latency: n/a (package, combinational helpers only).
// Backpressure: n/a.
package phase_2b_pkg;

    localparam int BITSTREAM_DEF = 64;
    localparam int K_W_DEF       = 2;

    // Widest word the helper functions handle; words are zero-extended into it.
    localparam int ROT_MAX_W = 1024;

    typedef logic [ROT_MAX_W-1:0] rot_word_t;

    // Functional definition of the rotation: r[i] = word[(i + amt) mod width].
    // Bits above 'width' are returned as zero.
    function automatic rot_word_t rotr(input rot_word_t word, input int amt, input int width);
        rot_word_t r;
        int        m;
        int        src;
        r = '0;
        if (width <= 0) begin
            return word;
        end
        m = amt % width;
        for (int i = 0; i < ROT_MAX_W; i++) begin
            if (i < width) begin
                src  = (i + m) % width;
                r[i] = word[src[9:0]];
            end
        end
        return r;
    endfunction

    // (2^j) mod n without overflow, for any stage index j.
    // Each rotator stage rotates by this amount, so the stages compose to k mod n.
    function automatic int pow2_mod(input int j, input int n);
        int r;
        r = 1 % n;
        for (int s = 0; s < j; s++) begin
            r = (r * 2) % n;
        end
        return r;
    endfunction

endpackage

// File: rtl/phase_rot.sv
// Combinational rotate-right of in_bits by (k mod BITSTREAM), one mux stage per bit of k.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs every cycle.
module phase_rot
    import phase_2b_pkg::*;
#(
    parameter int BITSTREAM = BITSTREAM_DEF,
    parameter int K_W       = K_W_DEF
) (
    input  logic [BITSTREAM-1:0] in_bits,
    input  logic [K_W-1:0]       k,
    output logic [BITSTREAM-1:0] out_bits
);

    // stage[0] is the raw input; stage[j+1] is stage[j] optionally rotated by 2^j mod BITSTREAM.
    // Reducing each step mod BITSTREAM keeps the chain correct for non-power-of-two widths
    // and for k wider than log2(BITSTREAM).
    logic [K_W:0][BITSTREAM-1:0] stage;

    assign stage[0] = in_bits;

    for (genvar j = 0; j < K_W; j++) begin : g_stage
        localparam int STEP = pow2_mod(j, BITSTREAM);

        // Stage j: fixed rotation by STEP, selected by k[j].
        assign stage[j+1] = k[j] ? BITSTREAM'(rotr(rot_word_t'(stage[j]), STEP, BITSTREAM))
                                 : stage[j];
    end

    assign out_bits = stage[K_W];

endmodule

// File: rtl/phase_2b.sv
// Registered rotate-right of a word by k mod BITSTREAM; optional parity via PHASE_2B_PARITY_EN.
// Latency: 1 cycle from in_valid to out_valid.
// Backpressure: none; accepts one word every cycle, out_bits holds while in_valid is low.
module phase_2b
    import phase_2b_pkg::*;
#(
    parameter int BITSTREAM = BITSTREAM_DEF,
    parameter int K_W       = K_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [K_W-1:0]       k,
    input  logic                 in_valid,
    input  logic [BITSTREAM-1:0] in_bits,
    output logic                 out_valid,
    output logic [BITSTREAM-1:0] out_bits
`ifdef PHASE_2B_PARITY_EN
    ,
    output logic                 out_parity
`endif
);

    logic [BITSTREAM-1:0] rot;

    phase_rot #(
        .BITSTREAM (BITSTREAM),
        .K_W       (K_W)
    ) u_rot (
        .in_bits  (in_bits),
        .k        (k),
        .out_bits (rot)
    );

    // Output register: reset wins over a concurrent valid; data only moves on valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bits  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_bits <= rot;
            end
        end
    end

`ifdef PHASE_2B_PARITY_EN
    // Parity captured with the data word so it always describes the current out_bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_parity <= 1'b0;
        end else if (in_valid) begin
            out_parity <= ^rot;
        end
    end
`else
    // No parity: the datapath above is the whole block.
`endif

endmodule

// File: tb/tb_phase_2b.sv
// Randomized and directed bench for phase_2b at 64/2 and 8/4 configurations.
// Latency: checks 1-cycle registered output against an in-bench model.
// Backpressure: none exercised (block has none).
module tb_phase_2b;

    localparam int NA = 64;
    localparam int KA = 2;
    localparam int NB = 8;
    localparam int KB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [KA-1:0] k_a;
    logic          va;
    logic [NA-1:0] ba;
    logic          ova;
    logic [NA-1:0] oba;

    logic [KB-1:0] k_b;
    logic          vb;
    logic [NB-1:0] bb;
    logic          ovb;
    logic [NB-1:0] obb;

`ifdef PHASE_2B_PARITY_EN
    logic opa;
    logic opb;
`endif

    phase_2b #(.BITSTREAM(NA), .K_W(KA)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .k         (k_a),
        .in_valid  (va),
        .in_bits   (ba),
        .out_valid (ova),
        .out_bits  (oba)
`ifdef PHASE_2B_PARITY_EN
        ,
        .out_parity(opa)
`endif
    );

    phase_2b #(.BITSTREAM(NB), .K_W(KB)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .k         (k_b),
        .in_valid  (vb),
        .in_bits   (bb),
        .out_valid (ovb),
        .out_bits  (obb)
`ifdef PHASE_2B_PARITY_EN
        ,
        .out_parity(opb)
`endif
    );

    int vectors = 0;
    int errors  = 0;

    // Behavioural model state
    logic [NA-1:0] ea;
    logic          eva;
    logic          epa;
    logic [NB-1:0] eb;
    logic          evb;
    logic          epb;
    bit            model_live = 1'b0;

    // Rotate right one bit at a time, km = amt mod width times.
    function automatic logic [NA-1:0] ref_a(input logic [NA-1:0] w, input int amt);
        int km;
        km = amt % NA;
        for (int s = 0; s < km; s++) w = {w[0], w[NA-1:1]};
        return w;
    endfunction

    function automatic logic [NB-1:0] ref_b(input logic [NB-1:0] w, input int amt);
        int km;
        km = amt % NB;
        for (int s = 0; s < km; s++) w = {w[0], w[NB-1:1]};
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: what each output register must hold after this edge.
    always @(posedge clk) begin
        if (rst) begin
            ea = '0; eva = 1'b0; epa = 1'b0;
            eb = '0; evb = 1'b0; epb = 1'b0;
            model_live = 1'b1;
        end else begin
            if (va) begin
                ea = ref_a(ba, int'(k_a)); eva = 1'b1; epa = ^ea;
            end else begin
                eva = 1'b0;
            end
            if (vb) begin
                eb = ref_b(bb, int'(k_b)); evb = 1'b1; epb = ^eb;
            end else begin
                evb = 1'b0;
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (model_live) begin
            check("a_valid", 64'(ova), 64'(eva));
            check("a_bits",  64'(oba), 64'(ea));
            check("b_valid", 64'(ovb), 64'(evb));
            check("b_bits",  64'(obb), 64'(eb));
`ifdef PHASE_2B_PARITY_EN
            check("a_parity", 64'(opa), 64'(epa));
            check("b_parity", 64'(opb), 64'(epb));
`endif
        end
    end

    initial begin
        logic [NA-1:0] r;

        rst = 1'b1; va = 1'b0; vb = 1'b0;
        k_a = '0; k_b = '0; ba = '0; bb = '0;
        tick();
        tick();
        check("reset_a_bits",  64'(oba), 64'h0);
        check("reset_a_valid", 64'(ova), 64'h0);
        check("reset_b_bits",  64'(obb), 64'h0);
`ifdef PHASE_2B_PARITY_EN
        check("reset_a_parity", 64'(opa), 64'h0);
`endif
        rst = 1'b0;
        tick();
        check("idle_after_reset_valid", 64'(ova), 64'h0);

        // Single bit rotates from LSB to MSB
        va = 1'b1; k_a = 2'd1; ba = 64'h0000_0000_0000_0001;
        tick();
        check("lsb_to_msb_bits",  64'(oba), 64'h8000_0000_0000_0000);
        check("lsb_to_msb_valid", 64'(ova), 64'h1);

        // Valid dropped for 3 cycles: garbage on inputs must not matter
        for (int i = 0; i < 3; i++) begin
            va = 1'b0; k_a = 2'($urandom); ba = {$urandom, $urandom};
            tick();
            check("hold_valid", 64'(ova), 64'h0);
            check("hold_bits",  64'(oba), 64'h8000_0000_0000_0000);
        end

        va = 1'b1; k_a = 2'd3; ba = 64'h0000_0000_0000_000F;
        tick();
        check("rot3_of_f", 64'(oba), 64'hE000_0000_0000_0001);
        k_a = 2'd2; ba = 64'h8000_0000_0000_0003;
        tick();
        check("rot2_wrap", 64'(oba), 64'hE000_0000_0000_0000);

        r = {$urandom, $urandom};
        k_a = 2'd0; ba = r;
        tick();
        check("k0_passthrough", 64'(oba), r);

`ifdef PHASE_2B_PARITY_EN
        k_a = 2'($urandom); ba = 64'h7;
        tick();
        check("parity_of_7", 64'(opa), 64'h1);
        k_a = 2'($urandom); ba = 64'h3;
        tick();
        check("parity_of_3", 64'(opa), 64'h0);
`endif

        // 101 back-to-back words, k cycling 0..3
        for (int n = 0; n < 101; n++) begin
            va = 1'b1; k_a = 2'(n % 4); ba = {$urandom, $urandom};
            tick();
            check("b2b_valid", 64'(ova), 64'h1);
        end
        va = 1'b0;

        // Narrow instance: k wider than log2(width) wraps mod 8
        vb = 1'b1; k_b = 4'd9; bb = 8'h01;
        tick();
        check("narrow_k9", 64'(obb), 64'h80);
        k_b = 4'd15; bb = 8'h81;
        tick();
        check("narrow_k15", 64'(obb), 64'h03);
        vb = 1'b0;

        // Reset together with valid discards the word
        rst = 1'b1; va = 1'b1; ba = {$urandom, $urandom}; vb = 1'b1; bb = 8'($urandom);
        tick();
        check("rst_vs_valid_bits",  64'(oba), 64'h0);
        check("rst_vs_valid_valid", 64'(ova), 64'h0);
        check("rst_vs_valid_b",     64'(obb), 64'h0);
        rst = 1'b0; va = 1'b0; vb = 1'b0;
        tick();

        // Random traffic on both instances with occasional reset
        for (int n = 0; n < 800; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            va  = ($urandom_range(0, 3) != 0);
            k_a = 2'($urandom);
            ba  = {$urandom, $urandom};
            vb  = ($urandom_range(0, 3) != 0);
            k_b = 4'($urandom);
            bb  = 8'($urandom);
            tick();
        end

        rst = 1'b0; va = 1'b0; vb = 1'b0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/phase_2b.md
PHASE_2B -- requirements
Module: phase_2b

Interface
REQ-001 SHALL have parameter BITSTREAM, default 64, giving the data word width in bits (legal range 4..1024).
REQ-002 SHALL have parameter K_W, default 2, giving the width of the rotate-amount input.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port k  input  K_W  the rotate-right amount, unsigned.
REQ-006 SHALL have port in_valid  input  1  qualifies in_bits and k in the current cycle.
REQ-007 SHALL have port in_bits  input  BITSTREAM  the input word.
REQ-008 SHALL have port out_valid  output  1  qualifies out_bits.
REQ-009 SHALL have port out_bits  output  BITSTREAM  the rotated word, registered.
REQ-010 SHALL have port out_parity  output  1  the XOR of out_bits, present only with PHASE_2B_PARITY_EN.

Function
REQ-011 SHALL compute rot = in_bits rotated right by km, where km = k mod BITSTREAM: rot[i] = in_bits[(i+km) mod BITSTREAM].
REQ-012 SHALL pass in_bits unchanged when km = 0.
REQ-013 SHALL move bits shifted out at the LSB end into the MSB end, with no bit lost or duplicated (popcount of out equals popcount of in).
REQ-014 SHALL register the result, with a latency of exactly 1 cycle: on an edge where in_valid=1, out_bits <= rot and out_valid <= 1 in the next cycle.
REQ-015 SHALL set out_valid <= 0 and hold out_bits at its previous value on an edge where in_valid=0.
REQ-016 SHALL accept one word per cycle, with back-to-back valid inputs producing back-to-back valid outputs and no backpressure.
REQ-017 SHALL keep k and in_bits don't-care when in_valid=0, with no effect on any output.
REQ-018 SHALL build the rotation datapath as log2-stage muxing (stage j rotates by 2^j when k[j]=1), purely combinational between the input ports and the output register.

Reset
REQ-019 SHALL drive out_bits=0, out_valid=0 and out_parity=0 on the edge after rst=1.
REQ-020 SHALL give rst priority over in_valid, discarding a word presented in a reset cycle.
REQ-021 SHALL require no reset of combinational logic, with the first valid output appearing 1 cycle after the first in_valid=1 following rst deassertion.

Configuration
REQ-022 SHALL compile the out_parity port and a registered parity bit (XOR-reduce of rot, captured alongside out_bits) when macro PHASE_2B_PARITY_EN is defined.
REQ-023 SHALL omit out_parity and all parity logic when PHASE_2B_PARITY_EN is undefined, with all other behaviour identical.

Structure
REQ-024 SHALL take shared package phase_2b_pkg to hold the default BITSTREAM (64), the default K_W (2) and a function rotr(word, amt) used as the functional definition of the rotation.
REQ-025 SHALL implement the combinational rotator in one sub-module, phase_rot (parameters BITSTREAM and K_W; ports in_bits, k, out_bits), instantiated by phase_2b, which adds only the registers and the valid/parity logic.

Verification
REQ-026 SHALL pass this check with BITSTREAM=64: in_bits=0x0000_0000_0000_0001, k=1, in_valid=1 -> next cycle out_bits=0x8000_0000_0000_0000, out_valid=1.
REQ-027 SHALL pass this check: in_bits=0x0000_0000_0000_000F, k=3 -> out_bits=0xE000_0000_0000_0001; and in_bits=0x8000_0000_0000_0003, k=2 -> out_bits=0xE000_0000_0000_0000.
REQ-028 SHALL pass this check: k=0 with a random in_bits -> out_bits equals in_bits; 101 back-to-back words with k = n mod 4 -> each out matches rotr 1 cycle later with out_valid held at 1.
REQ-029 SHALL pass this check: in_valid dropped for 3 cycles -> out_valid=0 and out_bits holding the last value; rst=1 asserted together with in_valid=1 -> out_bits=0, out_valid=0 next cycle.
REQ-030 SHALL pass this check with PHASE_2B_PARITY_EN: in_bits=0x0000_0000_0000_0007, any k -> out_parity=1; in_bits=0x3 -> out_parity=0.
REQ-031 SHALL pass this check with BITSTREAM=8, K_W=4: in_bits=0x01, k=9 -> out_bits=0x80 (k mod 8 = 1).
